// File: rtl/if_id_queue_pkg.sv
// Shared core definitions for the fetch/decode boundary.
package if_id_queue_pkg;

    localparam int unsigned CORE_XLEN = 32;

    // Canonical NOP (addi x0, x0, 0) presented to decode when nothing is queued.
    localparam logic [CORE_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One fetched instruction; pc occupies the upper half of the packed word.
    typedef struct packed {
        logic [CORE_XLEN-1:0] pc;
        logic [CORE_XLEN-1:0] instr;
    } fetch_entry_t;

    localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF/ID queue: one synchronous write port and one
// asynchronous read port. Contents are not reset; the control logic tracks
// which entries are live.
module if_id_queue_mem
    import if_id_queue_pkg::*;
#(
    parameter int unsigned W     = FETCH_ENTRY_W,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // Write the addressed entry on a push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue. All outputs are registered; the head entry is
// recomputed each cycle from the next read pointer so decode sees a new
// entry one cycle after it is pushed, never in the same cycle.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       stall_i,
    input  logic                       if_valid_i,
    input  logic [XLEN-1:0]            if_pc_i,
    input  logic [XLEN-1:0]            if_instr_i,
    output logic                       if_ready_o,
    output logic                       id_valid_o,
    output logic [XLEN-1:0]            id_pc_o,
    output logic [XLEN-1:0]            id_instr_o,
    input  logic                       id_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned EW = 2 * XLEN;

    // Reject depths that would break natural pointer wrap.
    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
            $error("if_id_queue: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [PW-1:0]   wptr_n;
    logic [PW-1:0]   rptr_n;
    logic [CW-1:0]   count_n;
    logic            push;
    logic            pop;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   rdata;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] instr_n;

    if_id_queue_mem #(
        .W     (EW),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_n),
        .rdata (rdata)
    );

    // Handshake decode, pointer/count update and next head selection.
    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        wptr_n  = wptr_q;
        rptr_n  = rptr_q;
        count_n = count_o;
        wdata   = {if_pc_i, if_instr_i};
        pc_n    = '0;
        instr_n = XLEN'(NOP_INSTR);

        if (flush_i) begin
            wptr_n  = '0;
            rptr_n  = '0;
            count_n = '0;
        end else begin
            push    = if_valid_i && if_ready_o;
            pop     = id_valid_o && id_ready_i && !stall_i;
            wptr_n  = push ? wptr_q + PW'(1) : wptr_q;
            rptr_n  = pop  ? rptr_q + PW'(1) : rptr_q;
            count_n = count_o + CW'(push) - CW'(pop);
        end

        // The entry being written this edge is not yet in storage, so bypass it
        // into the head register when it becomes the new head.
        if (count_n == '0) begin
            pc_n    = '0;
            instr_n = XLEN'(NOP_INSTR);
        end else if (push && (rptr_n == wptr_q)) begin
            pc_n    = if_pc_i;
            instr_n = if_instr_i;
        end else begin
            pc_n    = rdata[EW-1:XLEN];
            instr_n = rdata[XLEN-1:0];
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_o    <= '0;
            if_ready_o <= 1'b1;
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_instr_o <= XLEN'(NOP_INSTR);
        end else begin
            wptr_q     <= wptr_n;
            rptr_q     <= rptr_n;
            count_o    <= count_n;
            if_ready_o <= (count_n != CW'(DEPTH));
            id_valid_o <= (count_n != '0);
            id_pc_o    <= pc_n;
            id_instr_o <= instr_n;
        end
    end

endmodule
